// File: rtl/pcie_sq_rx_req.sv
// SQ-entry fetch request generator: splits "fetch N entries" commands into
// single 64-byte PCIe memory reads, issuing only when a tag and a FIFO slot are free.
module pcie_sq_rx_req #(
  parameter int         C_PCIE_ADDR_WIDTH  = 36,
  parameter int         P_FIFO_DEPTH_WIDTH = 4,
  parameter logic [4:0] P_TAG_PREFIX       = 5'b00000
) (
  input  logic                            pcie_user_clk,
  input  logic                            pcie_user_rst_n,
  input  logic                            sq_fetch_req,
  input  logic [C_PCIE_ADDR_WIDTH-7:0]    sq_fetch_addr,
  input  logic [3:0]                      sq_fetch_cnt,
  output logic                            sq_fetch_ack,
  output logic                            sq_fetch_done,
  output logic                            tx_mrd_req,
  output logic [C_PCIE_ADDR_WIDTH-3:0]    tx_mrd_addr,
  output logic [9:0]                      tx_mrd_len,
  output logic [7:0]                      tx_mrd_tag,
  input  logic                            tx_mrd_req_ack,
  output logic                            pcie_tag_alloc,
  output logic [7:0]                      pcie_alloc_tag,
  output logic                            pcie_tag_alloc_len,
  input  logic                            pcie_tag_full_n,
  input  logic [P_FIFO_DEPTH_WIDTH:0]     rear_full_addr,
  input  logic [P_FIFO_DEPTH_WIDTH:0]     fifo_front_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_REQ   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [C_PCIE_ADDR_WIDTH-7:0] LP_ADDR_ONE = {{(C_PCIE_ADDR_WIDTH-7){1'b0}}, 1'b1};

  state_t                          r_state;
  logic [C_PCIE_ADDR_WIDTH-7:0]    r_addr;
  logic [3:0]                      r_cnt;
  logic [2:0]                      r_tag;
  logic                            r_ack;
  logic                            r_done;
  logic                            r_req;

  logic [P_FIFO_DEPTH_WIDTH:0]     w_occupancy;
  logic                            w_slot_free;

  // Modular pointer difference absorbs the wrap bit; a free slot means occupancy < 2^W.
  assign w_occupancy = rear_full_addr - fifo_front_addr;
  assign w_slot_free = (w_occupancy[P_FIFO_DEPTH_WIDTH] == 1'b0);

  // Command sequencing and registered handshake outputs.
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= 4'd0;
      r_tag   <= 3'd0;
      r_ack   <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sq_fetch_req) begin
            r_ack   <= 1'b1;
            r_addr  <= sq_fetch_addr;
            r_cnt   <= sq_fetch_cnt;
            r_state <= (sq_fetch_cnt == 4'd0) ? S_DONE : S_CHECK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        // Re-entered after every issue so the tag manager's registered status is seen fresh.
        S_CHECK: begin
          if (pcie_tag_full_n && w_slot_free) begin
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_REQ: begin
          if (tx_mrd_req_ack) begin
            r_req   <= 1'b0;
            r_tag   <= r_tag + 3'd1;
            r_addr  <= r_addr + LP_ADDR_ONE;
            r_cnt   <= r_cnt - 4'd1;
            r_state <= (r_cnt == 4'd1) ? S_DONE : S_CHECK;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sq_fetch_ack       = r_ack;
  assign sq_fetch_done      = r_done;
  assign tx_mrd_req         = r_req;
  assign tx_mrd_addr        = {r_addr, 4'b0000};
  assign tx_mrd_len         = 10'd16;
  assign tx_mrd_tag         = {P_TAG_PREFIX, r_tag};
  assign pcie_alloc_tag     = {P_TAG_PREFIX, r_tag};
  assign pcie_tag_alloc_len = 1'b1;
  // Allocation coincides with the TX acceptance so the tag manager sees it in the same cycle.
  assign pcie_tag_alloc     = (r_state == S_REQ) && tx_mrd_req_ack;

endmodule
